// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass_pkg
//   Shared definitions for the register file and its dump sequencer.
//   Holds the default geometry and the dump FSM state encodings.
package regfile_bypass_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Dump FSM encodings, kept fixed so debug tooling can decode them.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;

endpackage

// File: rtl/regfile_dump_seq.sv
// regfile_dump_seq
//   Streams every register of the parent register file, one per cycle, to the
//   debug/UART unit. The sequencer publishes the index it wants (rd_index) and
//   the parent returns the bypassed contents on rd_data in the same cycle.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   dump_start        request a full dump (ignored while busy)
//   rd_index/rd_data  read request to the parent / bypassed data returned
//   dump_busy         sequencer active (combinational from state)
//   dump_valid        dump_addr/dump_data valid this cycle
//   dump_addr/data    reported index and its contents
//   dump_last         qualifies the final word
module regfile_dump_seq
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dump_start,
  output logic [ADDR_WIDTH-1:0] rd_index,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  dump_busy,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last
);

  // Last index is all ones; the compare, not the pointer wrap, ends the dump.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;

  assign rd_index  = ptr;
  assign dump_busy = (state == ST_DUMP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        ST_DUMP: begin
          dump_valid <= 1'b1;
          dump_addr  <= ptr;
          dump_data  <= rd_data;
          dump_last  <= (ptr == LAST_IDX);
          ptr        <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          if (dump_start) begin
            state <= ST_DUMP;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   MIPS general-purpose register file for the ID stage. Two registered read
//   ports with write-to-read bypass, one combinational bypassed read port for
//   branch comparison, stall-able read registers, optional hardwired-zero r0,
//   and a dump sequencer streaming all registers to the debug unit.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   RegWrite, write_register,
//   write_data                    WB write port
//   read_register_1/2             read indices
//   read_enable                   1 = load read_data_1/2, 0 = hold (stall)
//   read_data_1/2                 registered bypassed read data
//   wire_read_data_1              combinational bypassed read of read_register_1
//   dump_start, dump_busy,
//   dump_valid, dump_addr,
//   dump_data, dump_last          debug dump stream
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [DATA_WIDTH-1:0] wire_read_data_1,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  we;
  logic [ADDR_WIDTH-1:0] dump_index;
  logic [DATA_WIDTH-1:0] dump_rd_data;

  // Writes to a hardwired r0 are dropped here so neither the array nor the
  // bypass path ever sees them.
  assign we = RegWrite && !((ZERO_REG != 0) && (write_register == '0));

  // Shared by every read path: in-flight write wins, then hardwired zero,
  // then the stored value.
  function automatic logic [DATA_WIDTH-1:0] bypass_read(input logic [ADDR_WIDTH-1:0] a);
    if (we && (write_register == a)) begin
      return write_data;
    end else if ((ZERO_REG != 0) && (a == '0)) begin
      return '0;
    end else begin
      return regs[a];
    end
  endfunction

  assign wire_read_data_1 = bypass_read(read_register_1);
  assign dump_rd_data     = bypass_read(dump_index);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[write_register] <= write_data;
    end
  end

  // Read stage boundary: holds during stall, writes continue underneath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else if (read_enable) begin
      read_data_1 <= bypass_read(read_register_1);
      read_data_2 <= bypass_read(read_register_2);
    end
  end

  regfile_dump_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump_seq (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .rd_index   (dump_index),
    .rd_data    (dump_rd_data),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Two instances share stimulus: dut_a with a hardwired r0, dut_b with an
//   ordinary r0. A behavioural model (plain arrays and a dump index) predicts
//   every output and is compared on each falling edge; directed sequences add
//   literal expectations, followed by a randomized phase.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register_1, read_register_2;
  logic        read_enable;
  logic        dump_start;

  logic [31:0] rd1_a, rd2_a, wire_a, dd_a;
  logic [31:0] rd1_b, rd2_b, wire_b, dd_b;
  logic [4:0]  da_a, da_b;
  logic        busy_a, dv_a, dl_a, busy_b, dv_b, dl_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_register(write_register),
    .write_data(write_data), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_enable(read_enable),
    .read_data_1(rd1_a), .read_data_2(rd2_a), .wire_read_data_1(wire_a),
    .dump_start(dump_start), .dump_busy(busy_a), .dump_valid(dv_a),
    .dump_addr(da_a), .dump_data(dd_a), .dump_last(dl_a)
  );

  regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .write_register(write_register),
    .write_data(write_data), .read_register_1(read_register_1),
    .read_register_2(read_register_2), .read_enable(read_enable),
    .read_data_1(rd1_b), .read_data_2(rd2_b), .wire_read_data_1(wire_b),
    .dump_start(dump_start), .dump_busy(busy_b), .dump_valid(dv_b),
    .dump_addr(da_b), .dump_data(dd_b), .dump_last(dl_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models dut_a (hardwired r0), index 1 models dut_b.
  logic [31:0] m_mem [2][32];
  logic [31:0] e_rd1 [2];
  logic [31:0] e_rd2 [2];
  logic [31:0] e_dd  [2];
  logic [4:0]  e_da;
  logic        e_dv, e_dl;
  int          dump_idx = -1;
  bit          model_ok = 0;

  function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
    bit wen;
    wen = RegWrite && !(d == 0 && write_register == 5'd0);
    if (wen && write_register == a) return write_data;
    if (d == 0 && a == 5'd0) return 32'h0;
    return m_mem[d][a];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      model_ok = 1;
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 32; r++) m_mem[d][r] = 32'h0;
        e_rd1[d] = 32'h0;
        e_rd2[d] = 32'h0;
        e_dd[d]  = 32'h0;
      end
      e_da = 5'd0; e_dv = 1'b0; e_dl = 1'b0;
      dump_idx = -1;
    end else if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        if (read_enable) begin
          e_rd1[d] = m_read(d, read_register_1);
          e_rd2[d] = m_read(d, read_register_2);
        end
      end
      if (dump_idx >= 0) begin
        for (int d = 0; d < 2; d++) e_dd[d] = m_read(d, 5'(dump_idx));
        e_da = 5'(dump_idx);
        e_dv = 1'b1;
        e_dl = (dump_idx == 31);
        dump_idx = (dump_idx == 31) ? -1 : dump_idx + 1;
      end else begin
        e_dv = 1'b0;
        e_dl = 1'b0;
        if (dump_start) dump_idx = 0;
      end
      for (int d = 0; d < 2; d++) begin
        if (RegWrite && !(d == 0 && write_register == 5'd0))
          m_mem[d][write_register] = write_data;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("rd1_a",  rd1_a,  e_rd1[0]);
      chk("rd2_a",  rd2_a,  e_rd2[0]);
      chk("rd1_b",  rd1_b,  e_rd1[1]);
      chk("rd2_b",  rd2_b,  e_rd2[1]);
      chk("wire_a", wire_a, m_read(0, read_register_1));
      chk("wire_b", wire_b, m_read(1, read_register_1));
      chk("busy_a", 32'(busy_a), 32'(dump_idx >= 0));
      chk("busy_b", 32'(busy_b), 32'(dump_idx >= 0));
      chk("dv_a",   32'(dv_a), 32'(e_dv));
      chk("dv_b",   32'(dv_b), 32'(e_dv));
      chk("dl_a",   32'(dl_a), 32'(e_dl));
      chk("dl_b",   32'(dl_b), 32'(e_dl));
      chk("da_a",   32'(da_a), 32'(e_da));
      chk("da_b",   32'(da_b), 32'(e_da));
      chk("dd_a",   dd_a, e_dd[0]);
      chk("dd_b",   dd_b, e_dd[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  addrs [4];
    logic [31:0] exp_w;
    bit          hit;
    addrs = '{5'd0, 5'd1, 5'd2, 5'd31};

    reset = 1'b0; RegWrite = 1'b0; write_register = '0; write_data = '0;
    read_register_1 = '0; read_register_2 = '0; read_enable = 1'b1; dump_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("reset_dv", 32'(dv_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);

    // Reset values on registered reads
    for (int i = 0; i < 4; i++) begin
      read_register_1 = addrs[i];
      read_register_2 = addrs[i];
      tick();
      chk("reset_rd1", rd1_a, 32'h0);
      chk("reset_rd2", rd2_b, 32'h0);
    end

    // Same-cycle write/read bypass
    RegWrite = 1'b1; write_register = 5'd2; write_data = 32'hFFFF_FFFF; read_register_1 = 5'd2;
    #1 chk("bypass_wire", wire_a, 32'hFFFF_FFFF);
    tick();
    RegWrite = 1'b0;
    chk("bypass_rd1", rd1_a, 32'hFFFF_FFFF);

    // r0 hardwired on dut_a, ordinary on dut_b
    RegWrite = 1'b1; write_register = 5'd0; write_data = 32'h1234_5678;
    read_register_1 = 5'd0; read_register_2 = 5'd0;
    #1 chk("r0_wire_a", wire_a, 32'h0);
    chk("r0_wire_b", wire_b, 32'h1234_5678);
    tick();
    RegWrite = 1'b0;
    chk("r0_rd1_a", rd1_a, 32'h0);
    chk("r0_rd2_a", rd2_a, 32'h0);
    chk("r0_rd1_b", rd1_b, 32'h1234_5678);
    tick();
    chk("r0_hold_a", rd2_a, 32'h0);
    chk("r0_hold_b", rd2_b, 32'h1234_5678);
    chk("r0_wire2_a", wire_a, 32'h0);

    // Stall holds read_data_2 while the write lands
    RegWrite = 1'b1; write_register = 5'd5; write_data = 32'hA5A5_A5A5; read_register_2 = 5'd5;
    tick();
    chk("stall_load", rd2_a, 32'hA5A5_A5A5);
    read_enable = 1'b0; write_data = 32'h5A5A_5A5A;
    tick();
    RegWrite = 1'b0;
    chk("stall_hold1", rd2_a, 32'hA5A5_A5A5);
    tick();
    chk("stall_hold2", rd2_a, 32'hA5A5_A5A5);
    read_enable = 1'b1;
    tick();
    chk("stall_release", rd2_a, 32'h5A5A_5A5A);

    // Preload rk = k + 0x100 and dump
    for (int k = 0; k < 32; k++) begin
      RegWrite = 1'b1; write_register = 5'(k); write_data = 32'h100 + 32'(k);
      tick();
    end
    RegWrite = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("dump_busy_start", 32'(busy_a), 32'h1);
    for (int k = 0; k < 32; k++) begin
      RegWrite = (k == 10); write_register = 5'd20; write_data = 32'hDEAD_0020;
      dump_start = (k == 5);
      tick();
      exp_w = (k == 20) ? 32'hDEAD_0020 : 32'h100 + 32'(k);
      chk("dump_valid", 32'(dv_a), 32'h1);
      chk("dump_addr", 32'(da_a), 32'(k));
      chk("dump_data_a", dd_a, (k == 0) ? 32'h0 : exp_w);
      chk("dump_data_b", dd_b, exp_w);
      chk("dump_last", 32'(dl_a), 32'(k == 31));
    end
    RegWrite = 1'b0; dump_start = 1'b0;
    tick();
    chk("dump_end_valid", 32'(dv_a), 32'h0);
    chk("dump_end_busy", 32'(busy_a), 32'h0);

    // Reset mid-dump at word 10
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (dv_a && da_a == 5'd10) hit = 1;
    end
    chk("abort_reached_word10", 32'(hit), 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_valid", 32'(dv_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    for (int a = 0; a < 32; a++) begin
      read_register_1 = 5'(a); read_register_2 = 5'(a);
      tick();
      chk("abort_rd1_b", rd1_b, 32'h0);
      chk("abort_rd2_a", rd2_a, 32'h0);
    end
    chk("abort_no_valid", 32'(dv_b), 32'h0);

    // Randomized phase, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(199) != 0);
      RegWrite        = $urandom_range(1);
      write_register  = 5'($urandom);
      write_data      = $urandom;
      read_register_1 = ($urandom_range(3) == 0) ? write_register : 5'($urandom);
      read_register_2 = ($urandom_range(3) == 0) ? write_register : 5'($urandom);
      read_enable     = ($urandom_range(3) != 0);
      dump_start      = ($urandom_range(49) == 0);
      tick();
    end
    reset = 1'b1; RegWrite = 1'b0; dump_start = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
